// File: rtl/decoder3to8_scan.sv
// Registered 3-to-8 one-hot decoder with direct (valid/ready) and scan modes.
// Optional build macro DECODER3TO8_HOLD_LAST_EN keeps the last direct value on D after its dwell.
module decoder3to8_scan #(
    parameter int DWELL = 4,
    parameter int CW    = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       E,
    input  logic [2:0] S,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       scan,
    output logic [7:0] D,
    output logic [2:0] cur,
    output logic       busy
);

    localparam int            DWELL_EFF = (DWELL == 0) ? 1 : DWELL;
    localparam logic [CW-1:0] CNT_LAST  = CW'(DWELL_EFF - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HOLD,
        ST_SCAN
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    d_q, d_d;
    logic [2:0]    cur_q, cur_d;
    logic          busy_q, busy_d;

    logic [2:0]    nxt_idx;
    logic [7:0]    s_onehot;
    logic [7:0]    nxt_onehot;
    logic          dwell_done;

    // cur_q doubles as the scan index; in SCAN it always matches the lit line.
    assign nxt_idx    = cur_q + 3'd1;
    assign dwell_done = (cnt_q == CNT_LAST);

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_dec
            assign s_onehot[gi]   = (S == 3'(gi));
            assign nxt_onehot[gi] = (nxt_idx == 3'(gi));
        end
    endgenerate

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        d_d      = d_q;
        cur_d    = cur_q;
        busy_d   = busy_q;
        in_ready = 1'b0;
        if (!E) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            d_d     = 8'h00;
            cur_d   = 3'd0;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    in_ready = ~scan;
                    if (scan) begin
                        state_d = ST_SCAN;
                        cnt_d   = '0;
                        d_d     = 8'h01;
                        cur_d   = 3'd0;
                        busy_d  = 1'b1;
                    end else if (in_valid) begin
                        state_d = ST_HOLD;
                        cnt_d   = '0;
                        d_d     = s_onehot;
                        cur_d   = S;
                        busy_d  = 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (dwell_done) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                        busy_d  = 1'b0;
`ifdef DECODER3TO8_HOLD_LAST_EN
                        d_d     = d_q;
                        cur_d   = cur_q;
`else
                        d_d     = 8'h00;
                        cur_d   = 3'd0;
`endif
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                ST_SCAN: begin
                    // The current line always finishes its dwell before scan is sampled.
                    if (dwell_done) begin
                        cnt_d = '0;
                        if (scan) begin
                            d_d   = nxt_onehot;
                            cur_d = nxt_idx;
                        end else begin
                            state_d = ST_IDLE;
                            d_d     = 8'h00;
                            cur_d   = 3'd0;
                            busy_d  = 1'b0;
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    d_d     = 8'h00;
                    cur_d   = 3'd0;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            d_q     <= 8'h00;
            cur_q   <= 3'd0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            d_q     <= d_d;
            cur_q   <= cur_d;
            busy_q  <= busy_d;
        end
    end

    assign D    = d_q;
    assign cur  = cur_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_decoder3to8_scan.sv
// Directed bench for decoder3to8_scan: three instances with DWELL=4, 2 and 0.
module tb_decoder3to8_scan;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    // DWELL=4 instance: direct decode, abort, priority
    logic       e4 = 0, v4 = 0, sc4 = 0, rdy4, busy4;
    logic [2:0] s4 = 0, cur4;
    logic [7:0] d4;
    // DWELL=2 instance: scan wrap, scan exit, async reset
    logic       e2 = 0, v2 = 0, sc2 = 0, rdy2, busy2;
    logic [2:0] s2 = 0, cur2;
    logic [7:0] d2;
    // DWELL=0 instance: one-cycle lines
    logic       e0 = 0, v0 = 0, sc0 = 0, rdy0, busy0;
    logic [2:0] s0 = 0, cur0;
    logic [7:0] d0;

    decoder3to8_scan #(.DWELL(4), .CW(8)) u_dut4 (
        .clk(clk), .rst(rst), .E(e4), .S(s4), .in_valid(v4), .in_ready(rdy4),
        .scan(sc4), .D(d4), .cur(cur4), .busy(busy4)
    );
    decoder3to8_scan #(.DWELL(2), .CW(8)) u_dut2 (
        .clk(clk), .rst(rst), .E(e2), .S(s2), .in_valid(v2), .in_ready(rdy2),
        .scan(sc2), .D(d2), .cur(cur2), .busy(busy2)
    );
    decoder3to8_scan #(.DWELL(0), .CW(8)) u_dut0 (
        .clk(clk), .rst(rst), .E(e0), .S(s0), .in_valid(v0), .in_ready(rdy0),
        .scan(sc0), .D(d0), .cur(cur0), .busy(busy0)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end else begin
            $display("[TB] ok   %s: 0x%0h", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One direct transaction on the DWELL=4 instance, starting in IDLE.
    task automatic direct_one(input logic [2:0] idx);
        logic [7:0] exp_d;
        exp_d = 8'h01 << idx;
        check("dir_ready_idle", 32'(rdy4), 32'd1);
        s4 = idx;
        v4 = 1'b1;
        tick();
        v4 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("dir_D_hold", 32'(d4), 32'(exp_d));
            check("dir_onehot", 32'($onehot(d4)), 32'd1);
            check("dir_ready_hold", 32'(rdy4), 32'd0);
            if (k == 0) begin
                check("dir_cur", 32'(cur4), 32'(idx));
                check("dir_busy", 32'(busy4), 32'd1);
            end
            tick();
        end
        check("dir_D_after", 32'(d4), 32'd0);
        check("dir_busy_after", 32'(busy4), 32'd0);
    endtask

    initial begin
        logic [7:0] exp_d;
        int k;
        #1;
        check("rst_D", 32'(d4), 32'd0);
        check("rst_cur", 32'(cur4), 32'd0);
        check("rst_busy", 32'(busy4), 32'd0);
        check("rst_ready", 32'(rdy4), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        tick();
        e4 = 1'b1;
        e2 = 1'b1;
        e0 = 1'b1;
        #1;

        // Direct decode S=5, then sweep 0..7 back to back
        direct_one(3'd5);
        for (int i = 0; i < 8; i++) direct_one(3'(i));

        // E=0 during HOLD aborts on the next edge
        s4 = 3'd6;
        v4 = 1'b1;
        tick();
        v4 = 1'b0;
        check("abort_D_hold", 32'(d4), 32'h40);
        tick();
        e4 = 1'b0;
        tick();
        check("abort_D", 32'(d4), 32'd0);
        check("abort_busy", 32'(busy4), 32'd0);
        check("abort_cur", 32'(cur4), 32'd0);
        e4 = 1'b1;
        tick();

        // scan and in_valid together: scan wins, S not consumed
        sc4 = 1'b1;
        v4 = 1'b1;
        s4 = 3'd2;
        #1;
        check("prio_ready", 32'(rdy4), 32'd0);
        tick();
        sc4 = 1'b0;
        v4 = 1'b0;
        check("prio_D", 32'(d4), 32'h01);
        check("prio_cur", 32'(cur4), 32'd0);
        check("prio_busy", 32'(busy4), 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("prio_D_dwell", 32'(d4), 32'h01);
        end
        tick();
        check("prio_D_exit", 32'(d4), 32'd0);
        check("prio_ready_exit", 32'(rdy4), 32'd1);

        // Scan wrap with DWELL=2
        sc2 = 1'b1;
        tick();
        for (k = 0; k <= 22; k++) begin
            exp_d = 8'h01 << ((k / 2) % 8);
            check("scan_D", 32'(d2), 32'(exp_d));
            check("scan_onehot", 32'($onehot(d2)), 32'd1);
            check("scan_cur", 32'(cur2), 32'((k / 2) % 8));
            if (k < 22) tick();
        end
        // Drop scan during index 3's first cycle: it still finishes its dwell
        sc2 = 1'b0;
        tick();
        check("scanexit_D_last", 32'(d2), 32'h08);
        tick();
        check("scanexit_D", 32'(d2), 32'd0);
        check("scanexit_busy", 32'(busy2), 32'd0);
        check("scanexit_ready", 32'(rdy2), 32'd1);

        // DWELL=0: each line lasts one cycle
        s0 = 3'd2;
        v0 = 1'b1;
        tick();
        check("dw0_D_first", 32'(d0), 32'h04);
        s0 = 3'd4;
        tick();
`ifdef DECODER3TO8_HOLD_LAST_EN
        check("dw0_D_gap", 32'(d0), 32'h04);
`else
        check("dw0_D_gap", 32'(d0), 32'h00);
`endif
        check("dw0_busy_gap", 32'(busy0), 32'd0);
        tick();
        v0 = 1'b0;
        check("dw0_D_second", 32'(d0), 32'h10);
        tick();
`ifdef DECODER3TO8_HOLD_LAST_EN
        check("dw0_D_end", 32'(d0), 32'h10);
`else
        check("dw0_D_end", 32'(d0), 32'h00);
`endif

        // Async reset in the middle of SCAN with D=8'h10
        sc2 = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) tick();
        check("midrst_D_before", 32'(d2), 32'h10);
        rst = 1'b1;
        #1;
        check("midrst_D", 32'(d2), 32'd0);
        check("midrst_cur", 32'(cur2), 32'd0);
        check("midrst_busy", 32'(busy2), 32'd0);
        sc2 = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        tick();
        check("postrst_ready", 32'(rdy2), 32'd1);
        check("postrst_D", 32'(d2), 32'd0);
        check("postrst_busy", 32'(busy2), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
